// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the unified instruction/data memory port.
// One transaction at a time: grant, single-cycle strobe, fixed latency wait, registered ack.
module mem_port_arbiter #(
    parameter int AW      = 64,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [63:0]   d_wdata,
    output logic          d_ack,
    output logic [63:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [63:0]   mem_wdata,
    input  logic [63:0]   mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t        state_reg, state_next;
    logic          owner_reg, owner_next;     // 1 = data port owns the transaction
    logic          store_reg, store_next;
    logic          last_d_reg, last_d_next;   // 1 = data port was granted last
    logic [1:0]    cnt_reg, cnt_next;
    logic          i_ack_reg, i_ack_next;
    logic          d_ack_reg, d_ack_next;
    logic [31:0]   i_rdata_reg, i_rdata_next;
    logic [63:0]   d_rdata_reg, d_rdata_next;
    logic          mem_en_reg, mem_en_next;
    logic          mem_we_reg, mem_we_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [63:0]   mem_wdata_reg, mem_wdata_next;
    logic          busy_reg, busy_next;
    logic          grant_d;

    // Data wins if it is alone, or on a tie when instruction was granted last.
    assign grant_d = d_req && (!i_req || !last_d_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            store_reg     <= 1'b0;
            last_d_reg    <= 1'b0;
            cnt_reg       <= '0;
            i_ack_reg     <= 1'b0;
            d_ack_reg     <= 1'b0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            store_reg     <= store_next;
            last_d_reg    <= last_d_next;
            cnt_reg       <= cnt_next;
            i_ack_reg     <= i_ack_next;
            d_ack_reg     <= d_ack_next;
            i_rdata_reg   <= i_rdata_next;
            d_rdata_reg   <= d_rdata_next;
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        store_next     = store_reg;
        last_d_next    = last_d_reg;
        cnt_next       = cnt_reg;
        i_ack_next     = 1'b0;
        d_ack_next     = 1'b0;
        i_rdata_next   = i_rdata_reg;
        d_rdata_next   = d_rdata_reg;
        mem_en_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_next     = grant_d;
                    last_d_next    = grant_d;
                    store_next     = grant_d && d_we;
                    mem_addr_next  = grant_d ? d_addr : i_addr;
                    mem_wdata_next = grant_d ? d_wdata : '0;
                    // Strobes are registered here so they appear during ISSUE.
                    mem_en_next    = 1'b1;
                    mem_we_next    = grant_d && d_we;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = 2'(MEM_LAT - 1);
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == 2'd0) begin
                    if (owner_reg) begin
                        d_rdata_next = store_reg ? 64'd0 : mem_rdata;
                        d_ack_next   = 1'b1;
                    end else begin
                        i_rdata_next = mem_rdata[63:32];
                        i_ack_next   = 1'b1;
                    end
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    assign i_ack     = i_ack_reg;
    assign d_ack     = d_ack_reg;
    assign i_rdata   = i_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single-ported, byte-addressed, big-endian unified memory shared by instruction fetch and data load/store in the tinker core. It accepts one request at a time from an instruction port and a data port and grants them round-robin. It drives one memory access per transaction, waits a fixed memory latency, then returns registered read data with a one-cycle acknowledge. It sits between the core's fetch and execute logic and the memory.

## Interface
Parameters:
- AW, 64, address width, all ports
- MEM_LAT, 1, cycles from mem_en high to mem_rdata valid; legal range 1..4

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- i_req  in  1  instruction fetch request, held until i_ack
- i_addr  in  AW  fetch byte address, stable while i_req high
- i_ack  out  1  one-cycle pulse: fetch done, i_rdata valid this cycle
- i_rdata  out  32  instruction word = mem_rdata[63:32] (bytes addr..addr+3)
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req high
- d_addr  in  AW  data byte address
- d_wdata  in  64  store data
- d_ack  out  1  one-cycle pulse: data transaction done
- d_rdata  out  64  load data, valid with d_ack; 0 on store ack
- mem_en  out  1  memory access strobe, high exactly one cycle per transaction
- mem_we  out  1  write strobe, only with mem_en
- mem_addr  out  AW  memory byte address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if i_req or d_req is high at the clock edge, register the winner, copy its addr, we and wdata to the mem_* registers, go to ISSUE. Otherwise stay.
- Arbitration:
  - With a single requester, that requester wins.
  - With both requesting, the winner is the port not granted last. The last-grant register resets to "instruction", so the first tie goes to data.
  - The last-grant register updates on each grant.
- ISSUE: mem_en=1 and mem_we=(owner is data && d_we) for this cycle only. Load counter with MEM_LAT-1 and go to WAIT. With MEM_LAT=1, WAIT lasts one cycle.
- WAIT: decrement the counter. When it reaches 0, mem_rdata is valid this cycle; capture it into the owner's rdata register (d_rdata=0 for a store) and go to ACK.
- ACK: pulse the owner's ack, then return to IDLE. The other port's ack and rdata stay unchanged.
- The instruction port is read-only; mem_we is never asserted for it.
- Addresses pass through unmodified. There is no alignment check; wrap-around beyond memory size is the memory's concern.
- Requests are sampled only in IDLE. A req deasserted before grant is a withdrawn request. Once granted, a transaction completes regardless of req.
- The requester deasserts req on the edge closing the ack cycle, so the IDLE cycle after ACK sees only new requests.

## Timing
- Request high in cycle 0 (IDLE) -> mem_en in cycle 1 -> mem_rdata valid in cycle 1+MEM_LAT -> ack in cycle 2+MEM_LAT -> IDLE in cycle 3+MEM_LAT.
- Latency from req to ack is 2+MEM_LAT cycles. Maximum throughput is one transaction per 3+MEM_LAT cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: state=IDLE, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, last-grant=instruction, counter=0.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous). The in-flight transaction is dropped and no ack is issued. A write whose mem_en cycle already occurred stays committed in memory.
- A request arriving at the edge where the arbiter leaves ACK is seen in the following IDLE cycle; it is not lost.

## Test plan
- Single fetch, MEM_LAT=1, i_addr=0x2000, memory holds 0xC8400000_xxxxxxxx -> mem_en in cycle 1, i_ack in cycle 3 with i_rdata=0xC8400000, busy high in cycles 1-3.
- Store then load, MEM_LAT=2: d_we=1, d_addr=0x10000, d_wdata=0x0123456789ABCDEF -> one mem_en/mem_we cycle, d_ack in cycle 4 with d_rdata=0. Then a load from 0x10000 -> d_rdata=0x0123456789ABCDEF.
- Both ports request continuously from reset -> grants in the order D, I, D, I. No port is granted twice in a row, and mem_en fires once per grant.
- Fetch requested alone, d_req rises during WAIT -> fetch completes first; data is granted in the next IDLE cycle.
- Reset asserted during WAIT of a load -> all outputs 0 in the same cycle, no d_ack ever. A new request after reset release completes normally.
- MEM_LAT=4 sweep -> ack exactly 6 cycles after req, mem_en high exactly one cycle.
